// File: rtl/hex_ascii_serializer_pkg.sv
// Shared types and helpers for the hex ASCII serializer.
//   ser_state_t      serializer FSM state encoding
//   CHR_*            ASCII codes used for framing and digits
//   nibble_to_ascii  4-bit value -> ASCII hex digit, upper or lower case
package uart_mon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    TERM0 = 3'd4,
    TERM1 = 3'd5
  } ser_state_t;

  localparam logic [7:0] CHR_0    = 8'h30;
  localparam logic [7:0] CHR_X    = 8'h78;
  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;
  localparam logic [7:0] CHR_SP   = 8'h20;
  localparam logic [7:0] CHR_A_UP = 8'h41;
  localparam logic [7:0] CHR_A_LO = 8'h61;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n, input logic lower);
    if (n < 4'd10) return CHR_0 + {4'h0, n};
    return (lower ? CHR_A_LO : CHR_A_UP) + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/hex_ascii_serializer_if.sv
// Handshake bundle between the word source, the serializer and the UART TX.
//   in_valid/in_ready/in_data     word input handshake
//   out_valid/out_ready/out_byte  character output handshake
//   busy                          serializer is mid-word
// slave = serializer view, master = source/sink view.
interface hex_ascii_serializer_if #(
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_byte, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_byte, busy
  );
endinterface

// File: rtl/hex_ascii_serializer_nibble.sv
// Combinational nibble -> ASCII hex digit lookup.
//   nib    4-bit value
//   ascii  '0'-'9', then 'A'-'F' or 'a'-'f' depending on LOWERCASE
module hex_nibble_ascii
  import uart_mon_pkg::*;
#(
  parameter bit LOWERCASE = 1'b0
) (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);
  assign ascii = nibble_to_ascii(nib, LOWERCASE);
endmodule

// File: rtl/hex_ascii_serializer.sv
// Serializes a DATA_W-bit word as fixed-width ASCII hex, MSB digit first,
// optionally framed by a "0x" prefix and a CR LF or space terminator.
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  slave side of hex_ascii_serializer_if (word in, byte out, busy)
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// PFX0  | presenting '0'
// PFX1  | presenting 'x'
// DIGIT | presenting nibble idx (counts NDIG-1 down to 0)
// TERM0 | presenting CR (TERM_MODE 1) or space (TERM_MODE 2)
// TERM1 | presenting LF
module hex_ascii_serializer
  import uart_mon_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PREFIX_EN = 0,
  parameter int TERM_MODE = 1,
  parameter int LOWERCASE = 0
) (
  input logic clk,
  input logic rst,
  hex_ascii_serializer_if.slave bus
);
  localparam int NDIG   = (DATA_W + 3) / 4;
  localparam int WORD_W = 4 * NDIG;
  localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  ser_state_t        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              emit;

  logic [WORD_W-1:0] in_ext;
  logic [WORD_W-1:0] nib_src;
  logic [IDX_W-1:0]  nib_idx;
  logic [3:0]        nib;
  logic [7:0]        digit_ascii;

  assign in_ext = WORD_W'(bus.in_data);

  // The converter always looks at the digit that would be presented next:
  // the top digit of the incoming word while idle, the following digit while
  // in DIGIT, otherwise the digit the counter already points at.
  assign nib_src = (state_q == IDLE) ? in_ext : word_q;
  assign nib_idx = (state_q == IDLE)  ? IDX_W'(NDIG - 1) :
                   (state_q == DIGIT) ? idx_q - 1'b1 : idx_q;
  assign nib     = 4'(nib_src >> {nib_idx, 2'b00});

  hex_nibble_ascii #(.LOWERCASE(LOWERCASE != 0)) u_nib (
    .nib   (nib),
    .ascii (digit_ascii)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = in_ext;
          idx_d   = IDX_W'(NDIG - 1);
          state_d = (PREFIX_EN != 0) ? PFX0 : DIGIT;
          emit    = 1'b1;
        end
      end
      default: begin
        if (valid_q && bus.out_ready) begin
          emit = 1'b1;
          case (state_q)
            PFX0:  state_d = PFX1;
            PFX1:  state_d = DIGIT;
            DIGIT: begin
              idx_d = idx_q - 1'b1;
              if (idx_q == '0) state_d = (TERM_MODE == 0) ? IDLE : TERM0;
            end
            TERM0: state_d = (TERM_MODE == 1) ? TERM1 : IDLE;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase

    // Load the byte for the state being entered so it is registered with it.
    if (emit) begin
      valid_d = (state_d != IDLE);
      case (state_d)
        PFX0:    byte_d = CHR_0;
        PFX1:    byte_d = CHR_X;
        DIGIT:   byte_d = digit_ascii;
        TERM0:   byte_d = (TERM_MODE == 1) ? CHR_CR : CHR_SP;
        TERM1:   byte_d = CHR_LF;
        default: byte_d = byte_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_byte  = byte_q;

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// Directed bench for hex_ascii_serializer across five parameter sets.
// One driver/monitor is multiplexed onto the instance selected by sel.
module tb_hex_ascii_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b1;
  logic [63:0] drv_data = '0;

  logic       mon_valid, mon_in_ready, mon_busy;
  logic [7:0] mon_byte;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  // sel: 0 W16 P0 T1 upper | 1 W12 P1 T2 lower | 2 W10 P0 T1 | 3 W1 P0 T0 | 4 W7 P1 T1
  hex_ascii_serializer_if #(.DATA_W(16)) if0 ();
  hex_ascii_serializer_if #(.DATA_W(12)) if1 ();
  hex_ascii_serializer_if #(.DATA_W(10)) if2 ();
  hex_ascii_serializer_if #(.DATA_W(1))  if3 ();
  hex_ascii_serializer_if #(.DATA_W(7))  if4 ();

  assign if0.in_valid = drv_valid && (sel == 0);
  assign if1.in_valid = drv_valid && (sel == 1);
  assign if2.in_valid = drv_valid && (sel == 2);
  assign if3.in_valid = drv_valid && (sel == 3);
  assign if4.in_valid = drv_valid && (sel == 4);
  assign if0.in_data  = drv_data[15:0];
  assign if1.in_data  = drv_data[11:0];
  assign if2.in_data  = drv_data[9:0];
  assign if3.in_data  = drv_data[0:0];
  assign if4.in_data  = drv_data[6:0];
  assign if0.out_ready = drv_ready;
  assign if1.out_ready = drv_ready;
  assign if2.out_ready = drv_ready;
  assign if3.out_ready = drv_ready;
  assign if4.out_ready = drv_ready;

  hex_ascii_serializer #(.DATA_W(16), .PREFIX_EN(0), .TERM_MODE(1), .LOWERCASE(0))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  hex_ascii_serializer #(.DATA_W(12), .PREFIX_EN(1), .TERM_MODE(2), .LOWERCASE(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  hex_ascii_serializer #(.DATA_W(10), .PREFIX_EN(0), .TERM_MODE(1), .LOWERCASE(0))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  hex_ascii_serializer #(.DATA_W(1),  .PREFIX_EN(0), .TERM_MODE(0), .LOWERCASE(0))
    u3 (.clk(clk), .rst(rst), .bus(if3));
  hex_ascii_serializer #(.DATA_W(7),  .PREFIX_EN(1), .TERM_MODE(1), .LOWERCASE(0))
    u4 (.clk(clk), .rst(rst), .bus(if4));

  always_comb begin
    mon_valid    = 1'b0;
    mon_byte     = 8'h00;
    mon_in_ready = 1'b0;
    mon_busy     = 1'b0;
    case (sel)
      0: begin mon_valid = if0.out_valid; mon_byte = if0.out_byte; mon_in_ready = if0.in_ready; mon_busy = if0.busy; end
      1: begin mon_valid = if1.out_valid; mon_byte = if1.out_byte; mon_in_ready = if1.in_ready; mon_busy = if1.busy; end
      2: begin mon_valid = if2.out_valid; mon_byte = if2.out_byte; mon_in_ready = if2.in_ready; mon_busy = if2.busy; end
      3: begin mon_valid = if3.out_valid; mon_byte = if3.out_byte; mon_in_ready = if3.in_ready; mon_busy = if3.busy; end
      default: begin mon_valid = if4.out_valid; mon_byte = if4.out_byte; mon_in_ready = if4.in_ready; mon_busy = if4.busy; end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Bytes per word = 2*PREFIX_EN + NDIG + term length, from each instance's parameters.
  function automatic int word_bytes(input int s);
    int p, nd, tl;
    case (s)
      0: begin p = 0; nd = 4; tl = 2; end
      1: begin p = 1; nd = 3; tl = 1; end
      2: begin p = 0; nd = 3; tl = 2; end
      3: begin p = 0; nd = 1; tl = 0; end
      default: begin p = 1; nd = 2; tl = 2; end
    endcase
    return 2 * p + nd + tl;
  endfunction

  task automatic set_exp(input string s, input int term);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (term == 1) begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
    if (term == 2) exp_q.push_back(8'h20);
  endtask

  // mode 0: out_ready always 1; 1: out_ready follows a stall pattern;
  // 2: in_valid held with changing in_data while busy.
  task automatic run_word(input string tag, input int s, input logic [63:0] d, input int mode);
    int guard;
    int cyc;
    logic [7:0]  prev_byte;
    logic        prev_stall;
    logic [15:0] pat;
    pat = 16'b1001_0010_0110_1001;
    @(negedge clk);
    sel = s;
    guard = 0;
    while (!mon_in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk({tag, "_in_ready"}, mon_in_ready, 1'b1);
    drv_data  = d;
    drv_valid = 1'b1;
    drv_ready = 1'b1;
    @(negedge clk);
    if (mode == 2) drv_data = ~d;
    else drv_valid = 1'b0;
    chk({tag, "_latency"}, mon_valid, 1'b1);
    rx_q.delete();
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    cyc = 0;
    while (mon_valid && cyc < 200) begin
      if (prev_stall) chk({tag, "_stall_hold"}, mon_byte, prev_byte);
      if (mode == 2) chk({tag, "_busy"}, mon_busy, 1'b1);
      drv_ready = (mode == 1) ? pat[cyc % 16] : 1'b1;
      if (drv_ready) rx_q.push_back(mon_byte);
      prev_stall = !drv_ready;
      prev_byte  = mon_byte;
      if (mode == 2) drv_data = drv_data + 64'h1111;
      @(negedge clk);
      cyc++;
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    chk({tag, "_done_in_bound"}, (cyc < 200), 1'b1);
    chk({tag, "_idle_ready"}, mon_in_ready, 1'b1);
    chk({tag, "_idle_busy"}, mon_busy, 1'b0);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    chk({tag, "_bytes_per_word"}, rx_q.size(), word_bytes(s));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", if0.out_valid, 1'b0);
    chk("rst_byte", if0.out_byte, 8'h00);
    chk("rst_in_ready", if0.in_ready, 1'b1);
    chk("rst_busy", if0.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    set_exp("BEEF", 1);  run_word("beef", 0, 64'hBEEF, 0);
    set_exp("0x0a5", 2); run_word("w12_0a5", 1, 64'h0A5, 0);
    set_exp("0xfb3", 2); run_word("w12_fb3", 1, 64'hFB3, 0);
    set_exp("1234", 1);  run_word("stall", 0, 64'h1234, 1);
    set_exp("0x0a5", 2); run_word("w12_stall", 1, 64'h0A5, 1);
    set_exp("3FF", 1);   run_word("w10_3ff", 2, 64'h3FF, 0);
    set_exp("2A5", 1);   run_word("w10_2a5", 2, 64'h2A5, 0);
    set_exp("1", 0);     run_word("w1_1", 3, 64'h1, 0);
    set_exp("0", 0);     run_word("w1_0", 3, 64'h0, 0);
    set_exp("0x5A", 1);  run_word("w7_5a", 4, 64'h5A, 0);
    set_exp("9C07", 1);  run_word("hold_valid", 0, 64'h9C07, 2);

    // out_ready while idle must not produce anything
    sel = 0;
    drv_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready_noeffect", if0.out_valid, 1'b0);
    end

    // reset during the third digit of CAFE
    @(negedge clk);
    drv_data  = 64'hCAFE;
    drv_valid = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    chk("cafe_d0", if0.out_byte, 8'h43);
    @(negedge clk);
    chk("cafe_d1", if0.out_byte, 8'h41);
    @(negedge clk);
    chk("cafe_d2", if0.out_byte, 8'h46);
    rst = 1'b1;
    #1;
    chk("arst_valid", if0.out_valid, 1'b0);
    chk("arst_byte", if0.out_byte, 8'h00);
    chk("arst_in_ready", if0.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", if0.out_valid, 1'b0);
    set_exp("0001", 1);  run_word("after_rst", 0, 64'h0001, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
